// File: rtl/binary_to_excess3.sv
// Registered binary-to-Excess-3 converter: each 4-bit nibble becomes (nibble + 3) mod 16,
// with per-nibble carry-out and BCD-range flags, one-cycle latency, valid-qualified.
module binary_to_excess3 #(
    parameter int NIBBLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   B_IN,
    input  logic                   in_valid,
    output logic [4*NIBBLES-1:0]   EX_OUT,
    output logic                   out_valid,
    output logic [NIBBLES-1:0]     carry,
    output logic [NIBBLES-1:0]     bcd_ok
);

    logic [4*NIBBLES-1:0] ex_d,    ex_q;
    logic [NIBBLES-1:0]   carry_d, carry_q;
    logic [NIBBLES-1:0]   bcd_d,   bcd_q;
    logic                 valid_q;

    // Each nibble gets its own 5-bit adder so no carry can leak into the next digit.
    for (genvar k = 0; k < NIBBLES; k++) begin : g_nibble
        logic [4:0] sum;
        assign sum              = {1'b0, B_IN[4*k +: 4]} + 5'd3;
        assign ex_d[4*k +: 4]   = sum[3:0];
        assign carry_d[k]       = sum[4];
        assign bcd_d[k]         = (B_IN[4*k +: 4] <= 4'd9);
    end

    // NOTE: non-blocking assignments in sequential logic so every register samples
    // pre-edge values; data registers load only when in_valid, otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            carry_q <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                ex_q    <= ex_d;
                carry_q <= carry_d;
                bcd_q   <= bcd_d;
            end
        end
    end

    assign EX_OUT    = ex_q;
    assign carry     = carry_q;
    assign bcd_ok    = bcd_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_binary_to_excess3.sv
// Self-checking bench for binary_to_excess3: one 1-nibble and one 2-nibble instance,
// table-driven vectors fed through a scoreboard queue and checked when out_valid fires.
module tb_binary_to_excess3;

    typedef struct {
        logic [7:0] b;
        logic [7:0] ex;
        logic [1:0] c;
        logic [1:0] ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] b1;
    logic       v1;
    logic [3:0] ex1;
    logic       ov1;
    logic [0:0] c1;
    logic [0:0] ok1;
    logic [7:0] b2;
    logic       v2;
    logic [7:0] ex2;
    logic       ov2;
    logic [1:0] c2;
    logic [1:0] ok2;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl1 [16];
    vec_t tbl2 [6];
    vec_t q1 [$];
    vec_t q2 [$];
    logic ev1 = 1'b0;
    logic ev2 = 1'b0;

    always #5 clk = ~clk;

    binary_to_excess3 #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .B_IN(b1), .in_valid(v1),
        .EX_OUT(ex1), .out_valid(ov1), .carry(c1), .bcd_ok(ok1)
    );

    binary_to_excess3 #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .B_IN(b2), .in_valid(v2),
        .EX_OUT(ex2), .out_valid(ov2), .carry(c2), .bcd_ok(ok2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive1(input vec_t t, input logic v);
        @(posedge clk);
        #1;
        b1 = t.b[3:0];
        v1 = v;
        if (v) q1.push_back(t);
    endtask

    task automatic drive2(input vec_t t, input logic v);
        @(posedge clk);
        #1;
        b2 = t.b;
        v2 = v;
        if (v) q2.push_back(t);
    endtask

    // Expected out_valid: whatever in_valid was at the last edge, cleared by reset.
    // Reset also discards every pending expectation.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ev1 = 1'b0;
            ev2 = 1'b0;
            q1.delete();
            q2.delete();
        end else begin
            ev1 = v1;
            ev2 = v2;
        end
    end

    always @(negedge clk) begin
        vec_t e;
        check("out_valid1", ov1, ev1);
        if (ov1) begin
            check("q1_pending", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("ex1", ex1, e.ex[3:0]);
                check("carry1", c1, e.c[0]);
                check("bcd_ok1", ok1, e.ok[0]);
            end
        end
    end

    always @(negedge clk) begin
        vec_t e;
        check("out_valid2", ov2, ev2);
        if (ov2) begin
            check("q2_pending", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                check("ex2", ex2, e.ex);
                check("carry2", c2, e.c);
                check("bcd_ok2", ok2, e.ok);
            end
        end
    end

    initial begin
        //               b       ex      carry   bcd_ok
        tbl1[0]  = '{8'h0, 8'h3, 2'b0, 2'b1};
        tbl1[1]  = '{8'h1, 8'h4, 2'b0, 2'b1};
        tbl1[2]  = '{8'h2, 8'h5, 2'b0, 2'b1};
        tbl1[3]  = '{8'h3, 8'h6, 2'b0, 2'b1};
        tbl1[4]  = '{8'h4, 8'h7, 2'b0, 2'b1};
        tbl1[5]  = '{8'h5, 8'h8, 2'b0, 2'b1};
        tbl1[6]  = '{8'h6, 8'h9, 2'b0, 2'b1};
        tbl1[7]  = '{8'h7, 8'hA, 2'b0, 2'b1};
        tbl1[8]  = '{8'h8, 8'hB, 2'b0, 2'b1};
        tbl1[9]  = '{8'h9, 8'hC, 2'b0, 2'b1};
        tbl1[10] = '{8'hA, 8'hD, 2'b0, 2'b0};
        tbl1[11] = '{8'hB, 8'hE, 2'b0, 2'b0};
        tbl1[12] = '{8'hC, 8'hF, 2'b0, 2'b0};
        tbl1[13] = '{8'hD, 8'h0, 2'b1, 2'b0};
        tbl1[14] = '{8'hE, 8'h1, 2'b1, 2'b0};
        tbl1[15] = '{8'hF, 8'h2, 2'b1, 2'b0};

        tbl2[0]  = '{8'h9F, 8'hC2, 2'b01, 2'b10};
        tbl2[1]  = '{8'h00, 8'h33, 2'b00, 2'b11};
        tbl2[2]  = '{8'hDA, 8'h0D, 2'b10, 2'b00};
        tbl2[3]  = '{8'h7C, 8'hAF, 2'b00, 2'b10};
        tbl2[4]  = '{8'hFF, 8'h22, 2'b11, 2'b00};
        tbl2[5]  = '{8'h3E, 8'h61, 2'b01, 2'b10};

        rst = 1'b1;
        b1  = '0;
        v1  = 1'b0;
        b2  = '0;
        v2  = 1'b0;

        // Inputs are ignored while reset is held, even with in_valid high.
        repeat (2) @(posedge clk);
        #1;
        v1 = 1'b1;
        b1 = 4'h7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex1", ex1, 0);
        check("rst_carry1", c1, 0);
        check("rst_bcd1", ok1, 0);
        check("rst_ov1", ov1, 0);
        check("rst_ex2", ex2, 0);
        v1  = 1'b0;
        rst = 1'b0;

        // Exhaustive back-to-back sweep on the single-nibble instance.
        for (int i = 0; i < 16; i++) drive1(tbl1[i], 1'b1);
        drive1(tbl1[0], 1'b0);

        // Hold: one valid 5, then 11 with in_valid low; result must stay 8.
        drive1(tbl1[5], 1'b1);
        drive1(tbl1[11], 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("hold_ex1", ex1, 4'h8);
        end

        // Two-nibble vectors: no carry between digits.
        for (int i = 0; i < 6; i++) drive2(tbl2[i], 1'b1);
        drive2(tbl2[0], 1'b0);

        // Streaming run of 16 pseudo-random valid inputs.
        for (int i = 0; i < 16; i++) drive1(tbl1[$urandom_range(0, 15)], 1'b1);

        // Mid-stream asynchronous reset, off the clock edge.
        for (int i = 0; i < 4; i++) drive1(tbl1[$urandom_range(0, 15)], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ex1", ex1, 0);
        check("mid_rst_carry1", c1, 0);
        check("mid_rst_bcd1", ok1, 0);
        check("mid_rst_ov1", ov1, 0);
        repeat (2) @(posedge clk);
        #1;
        v1  = 1'b0;
        rst = 1'b0;
        repeat (3) drive1(tbl1[0], 1'b0);
        drive1(tbl1[13], 1'b1);
        drive1(tbl1[9], 1'b1);
        drive1(tbl1[0], 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_to_excess3.md
# binary_to_excess3

Registered binary-to-Excess-3 code converter. Each 4-bit nibble of the input word is replaced by its value plus 3, modulo 16. The block sits on a valid-qualified data path between a binary/BCD source and downstream Excess-3 consumers, for example self-complementing arithmetic or display logic. It also reports per-nibble carry-out and a BCD-range flag.

## Interface
Parameters:
- NIBBLES, default 1: number of independent 4-bit digits converted in parallel; must be ≥ 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- B_IN  input  4*NIBBLES  binary input word; nibble k = B_IN[4k+3:4k].
- in_valid  input  1  B_IN is sampled on a rising clk edge only when this is high.
- EX_OUT  output  4*NIBBLES  registered Excess-3 result, per nibble.
- out_valid  output  1  high for exactly one cycle per accepted input.
- carry  output  NIBBLES  carry[k] = bit 4 of (nibble k + 3), i.e. set for nibble values 13..15.
- bcd_ok  output  NIBBLES  bcd_ok[k] = 1 when nibble k ≤ 9 (valid BCD digit).

## Operation
- Per nibble, EX_OUT[k] = (B_IN[k] + 3) mod 16. The nibbles are independent and no carry propagates between them.
- Full 4-bit mapping, input to output: 0→3, 1→4, 2→5, 3→6, 4→7, 5→8, 6→9, 7→10, 8→11, 9→12, 10→13, 11→14, 12→15, 13→0, 14→1, 15→2.
- Inputs 10..15 are not legal BCD. They are still converted using the modulo-16 rule above and are never saturated or blocked. bcd_ok is 0 for them. carry is 1 for 13..15 only.
- EX_OUT, carry and bcd_ok all load together on an accepting edge (in_valid = 1).
- When in_valid = 0 the data outputs hold their last values and out_valid drops to 0.
- The block has no back-pressure: every cycle with in_valid = 1 produces exactly one result.

## Timing
- Latency is 1 cycle. An input sampled at edge N appears on EX_OUT/carry/bcd_ok at edge N, and out_valid is high during the cycle following edge N.
- Throughput is one conversion per cycle, so back-to-back valid inputs give back-to-back out_valid pulses.
- Reset values, applied immediately on rst assertion and independent of clk:
  - EX_OUT = 0
  - carry = 0
  - bcd_ok = 0
  - out_valid = 0
- While rst is high, inputs are ignored. The first accepting edge is the first rising clk edge with rst low.
- Reset in the middle of a stream discards the in-flight result: out_valid goes low at once and does not reappear for that input.
- All outputs come directly from registers, with no combinational path from input to output.

## Test plan
- Reset check: assert rst asynchronously mid-cycle with valid traffic running. All outputs must go to 0 at once, and out_valid must stay 0 until an input is accepted after rst is released.
- Exhaustive sweep, NIBBLES=1: drive B_IN = 0..15 with in_valid held high, one value per cycle. Each following cycle must show EX_OUT = B_IN+3 mod 16 with out_valid = 1. Spot values: 0→3, 9→12, 12→15, 13→0, 15→2.
- Flag check:
  - B_IN=9 → bcd_ok=1, carry=0.
  - B_IN=10 → bcd_ok=0, carry=0.
  - B_IN=13 → bcd_ok=0, carry=1.
- Hold behaviour: apply B_IN=5 with in_valid=1 for one cycle, then change B_IN to 11 with in_valid=0. EX_OUT must stay 8 and out_valid must be high for exactly one cycle.
- Multi-nibble, NIBBLES=2: B_IN=8'h9F → EX_OUT=8'hC2, carry=2'b01, bcd_ok=2'b10. This confirms there is no inter-nibble carry.
- Streaming: feed 16 consecutive valid inputs. This must produce 16 consecutive out_valid cycles, in order, each with 1-cycle latency.
